// File: rtl/alu_issue.sv
// alu_issue: two-stage issue pipeline in front of an external combinational ALU; latency 2, one op per cycle.
// Backpressure: S2 holds while rsp_ready=0, S1 holds behind it, req_ready drops; ALU_ISSUE_PERF_EN adds perf counters.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_class,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_illegal,
    input  logic        flush,
    output logic [31:0] perf_ops,
    output logic [15:0] perf_illegal
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SLT = 4'b1010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b0111;

    logic        valid1_q, valid1_d;
    logic [3:0]  op1_q, op1_d;
    logic [31:0] a1_q, a1_d, b1_q, b1_d;
    logic        ill1_q, ill1_d;
    logic        valid2_q, valid2_d;
    logic [31:0] res2_q, res2_d;
    logic        zero2_q, zero2_d;
    logic        ill2_q, ill2_d;

    logic [3:0]  dec_op;
    logic        dec_ill;
    logic        s2_adv, s1_adv, accept;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (req_class)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_OR;
            default: begin
                case (req_funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b100110: dec_op = OP_XOR;
                    6'b100111: dec_op = OP_NOR;
                    6'b101010: dec_op = OP_SLT;
                    default:   dec_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        s2_adv    = !valid2_q || rsp_ready;
        s1_adv    = valid1_q && s2_adv;
        req_ready = !rst && !flush && (!valid1_q || s2_adv);
        accept    = req_valid && req_ready;

        valid1_d = valid1_q;
        op1_d    = op1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        ill1_d   = ill1_q;
        valid2_d = valid2_q;
        res2_d   = res2_q;
        zero2_d  = zero2_q;
        ill2_d   = ill2_q;

        if (accept) begin
            valid1_d = 1'b1;
            op1_d    = dec_op;
            a1_d     = req_a;
            b1_d     = req_b;
            ill1_d   = dec_ill;
        end else if (s1_adv) begin
            valid1_d = 1'b0;
        end

        if (s1_adv) begin
            valid2_d = 1'b1;
            res2_d   = alu_result;
            zero2_d  = alu_zero;
            ill2_d   = ill1_q;
        end else if (rsp_ready) begin
            valid2_d = 1'b0;
        end

        // Flush drops both stages, including a response being handshaken this cycle.
        if (flush) begin
            valid1_d = 1'b0;
            valid2_d = 1'b0;
        end
    end

    always_comb begin
        alu_op      = valid1_q ? op1_q : 4'b0000;
        alu_a       = valid1_q ? a1_q  : 32'd0;
        alu_b       = valid1_q ? b1_q  : 32'd0;
        rsp_valid   = valid2_q && !rst;
        rsp_result  = rst ? 32'd0 : res2_q;
        rsp_zero    = !rst && zero2_q;
        rsp_illegal = !rst && ill2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            op1_q    <= 4'b0000;
            a1_q     <= 32'd0;
            b1_q     <= 32'd0;
            ill1_q   <= 1'b0;
            valid2_q <= 1'b0;
            res2_q   <= 32'd0;
            zero2_q  <= 1'b0;
            ill2_q   <= 1'b0;
        end else begin
            valid1_q <= valid1_d;
            op1_q    <= op1_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            ill1_q   <= ill1_d;
            valid2_q <= valid2_d;
            res2_q   <= res2_d;
            zero2_q  <= zero2_d;
            ill2_q   <= ill2_d;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic        rsp_fire;
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_illegal_q, perf_illegal_d;

    always_comb begin
        rsp_fire       = valid2_q && rsp_ready && !flush;
        perf_ops_d     = perf_ops_q + {31'd0, rsp_fire};
        perf_illegal_d = perf_illegal_q + {15'd0, rsp_fire && ill2_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q     <= 32'd0;
            perf_illegal_q <= 16'd0;
        end else begin
            perf_ops_q     <= perf_ops_d;
            perf_illegal_q <= perf_illegal_d;
        end
    end

    assign perf_ops     = perf_ops_q;
    assign perf_illegal = perf_illegal_q;
`else
    assign perf_ops     = 32'd0;
    assign perf_illegal = 16'd0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed vectors push expected responses, a forked monitor pops on each handshake.
module tb_alu_issue;

`ifdef ALU_ISSUE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready;
    logic [1:0]  req_class;
    logic [5:0]  req_funct;
    logic [31:0] req_a, req_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_illegal, flush;
    logic [31:0] rsp_result, perf_ops;
    logic [15:0] perf_illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_ops = 0;
    int   exp_ill = 0;
    int   run_len = 0;
    int   max_run = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .flush(flush),
        .perf_ops(perf_ops), .perf_illegal(perf_illegal)
    );

    // External combinational ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_op)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b1010: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0100: alu_result = alu_a & alu_b;
            4'b0101: alu_result = alu_a | alu_b;
            4'b0110: alu_result = alu_a ^ alu_b;
            4'b0111: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                sb.delete();
                run_len = 0;
                if (rst) begin
                    exp_ops = 0;
                    exp_ill = 0;
                end
            end else if (rsp_valid && rsp_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got result 0x%08h, expected no response", rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
                    exp_ops++;
                    if (e.ill) exp_ill++;
                end
            end else begin
                run_len = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] cls, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ez, input logic ei);
        req_valid = 1'b1;
        req_class = cls;
        req_funct = fn;
        req_a     = a;
        req_b     = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                sb.push_back({er, ez, ei});
                step();
                return;
            end
            step();
        end
        n_vec++;
        n_err++;
        $display("FAIL issue_timeout: got no req_ready in 50 cycles, expected acceptance");
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (sb.size() == 0) return;
            step();
        end
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_alu_op", 32'(alu_op), 32'd0);
        chk("post_rst_perf_ops", perf_ops, 32'd0);
        chk("post_rst_perf_illegal", 32'(perf_illegal), 32'd0);
        step();
    endtask

    initial begin
        int acc;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        req_class = 2'b00; req_funct = 6'd0; req_a = 32'd0; req_b = 32'd0;
        fork
            monitor();
        join_none
        step();
        do_reset();

        // SLT with negative operand, latency check
        issue(2'b10, 6'b101010, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b0, 1'b0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("slt_alu_op", 32'(alu_op), 32'hA);
        chk("slt_alu_a", alu_a, 32'hFFFF_FFFE);
        step();
        @(negedge clk);
        chk("slt_latency2_rsp_valid", 32'(rsp_valid), 32'd1);
        step();

        issue(2'b01, 6'b111111, 32'h1234_5678, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        issue(2'b10, 6'b111111, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("illegal_alu_op", 32'(alu_op), 32'd0);
        chk("illegal_alu_a", alu_a, 32'd3);
        step();
        drain();
        @(negedge clk);
        chk("perf_illegal_after_illegal", 32'(perf_illegal), PERF_ON ? 32'd1 : 32'd0);
        chk("perf_ops_after_three", perf_ops, PERF_ON ? 32'd3 : 32'd0);
        step();

        // Full decode table, issued back to back
        issue(2'b10, 6'b100000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        issue(2'b10, 6'b100010, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        issue(2'b10, 6'b100100, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
        issue(2'b10, 6'b100101, 32'hF0F0, 32'h0F0F, 32'hFFFF, 1'b0, 1'b0);
        issue(2'b10, 6'b100110, 32'hFFFF, 32'hFFFF, 32'd0, 1'b1, 1'b0);
        issue(2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(2'b10, 6'b101010, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        issue(2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        issue(2'b11, 6'b000000, 32'hA0, 32'h0B, 32'hAB, 1'b0, 1'b0);
        issue(2'b10, 6'b000000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
        drain();

        // Eight back-to-back ADDs from a clean counter state
        do_reset();
        max_run = 0;
        for (int i = 0; i < 8; i++)
            issue(2'b00, 6'd0, 32'(i), 32'd1, 32'(i + 1), 1'b0, 1'b0);
        drain();
        @(negedge clk);
        chk("stream_consecutive_rsp", 32'(max_run), 32'd8);
        chk("stream_perf_ops", perf_ops, PERF_ON ? 32'd8 : 32'd0);
        step();

        // Backpressure: three requests offered while rsp_ready is low
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1; req_class = 2'b00; req_funct = 6'd0; req_a = 32'd10; req_b = 32'd20;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (req_ready) begin
                if (acc == 0) sb.push_back({32'd30, 1'b0, 1'b0});
                else          sb.push_back({32'd99, 1'b0, 1'b0});
                acc++;
            end
            if (rsp_valid) chk("stall_rsp_result", rsp_result, 32'd30);
            step();
            if (acc == 1) begin
                req_class = 2'b01; req_a = 32'd100; req_b = 32'd1;
            end else if (acc == 2) begin
                req_class = 2'b11; req_a = 32'hF0; req_b = 32'h0F;
            end
        end
        @(negedge clk);
        chk("stall_accepted", 32'(acc), 32'd2);
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rsp_result_held", rsp_result, 32'd30);
        step();
        rsp_ready = 1'b1;
        issue(2'b11, 6'd0, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        drain();

        // Flush with both stages full
        rsp_ready = 1'b0;
        issue(2'b00, 6'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        issue(2'b00, 6'd0, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);
        flush = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_flush_req_ready", 32'(req_ready), 32'd1);
        chk("post_flush_perf_ops", perf_ops, PERF_ON ? 32'(exp_ops) : 32'd0);
        chk("post_flush_exp_ops", 32'(exp_ops), 32'd11);
        step();
        idle(3);

        // Reset with both stages full
        rsp_ready = 1'b0;
        issue(2'b00, 6'd0, 32'd6, 32'd6, 32'd12, 1'b0, 1'b0);
        issue(2'b10, 6'b111110, 32'd1, 32'd0, 32'd1, 1'b0, 1'b1);
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_rst_perf_ops", perf_ops, 32'd0);
        chk("after_rst_perf_illegal", 32'(perf_illegal), 32'd0);
        chk("after_rst_req_ready", 32'(req_ready), 32'd1);
        step();
        idle(4);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: req_valid  in  1, req_ready  out  1  request handshake.
REQ-004 SHALL have: req_class  in  2  op class: 00 add, 01 sub, 10 R-type (use funct), 11 or.
REQ-005 SHALL have: req_funct  in  6, req_a  in  32, req_b  in  32  funct and operands.
REQ-006 SHALL have: alu_op  out  4, alu_a  out  32, alu_b  out  32  drive to the combinational ALU.
REQ-007 SHALL have: alu_result  in  32, alu_zero  in  1  from the ALU, same cycle.
REQ-008 SHALL have: rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-009 SHALL have: rsp_result  out  32, rsp_zero  out  1, rsp_illegal  out  1  response payload.
REQ-010 SHALL have: flush  in  1  discard all in-flight ops.
REQ-011 SHALL have: perf_ops  out  32, perf_illegal  out  16  performance counters.

Function
REQ-012 SHALL encode alu_op: ADD 0000, SUB 0010, SLT 1010, AND 0100, OR 0101, XOR 0110, NOR 0111.
REQ-013 SHALL decode class 10 funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
REQ-014 SHALL, for class 10 with any other funct, issue ADD and set the op's illegal flag to 1; classes 00/01/11 never illegal and ignore funct.
REQ-015 SHALL be a two-stage pipeline: S1 (valid1, decoded op, a, b) drives alu_op/alu_a/alu_b directly from registers; S2 (valid2, result, zero, illegal) drives rsp_*.
REQ-016 SHALL drive alu_op=0000, alu_a=0, alu_b=0 whenever valid1=0.
REQ-017 SHALL load S2 from alu_result/alu_zero/S1 illegal when valid1=1 and (valid2=0 or rsp_ready=1).
REQ-018 SHALL assert req_ready = !flush and (valid1=0 or S1 advances this cycle); req accepted when req_valid and req_ready both 1.
REQ-019 SHALL give latency 2: request accepted in cycle n -> rsp_valid=1 in cycle n+2 if rsp_ready held 1.
REQ-020 SHALL sustain one op per cycle with rsp_ready=1; no bubbles, no drops, no duplicates.
REQ-021 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0; S1 holds while S2 is full and stalled.
REQ-022 SHALL, on flush=1, clear valid1 and valid2 at that edge, accept nothing that cycle; the S2 response presented that cycle is discarded even if rsp_ready=1 and is not counted.
REQ-023 SHALL increment perf_ops on each rsp handshake (excluding flush cycles) and perf_illegal when that response has rsp_illegal=1; both wrap modulo width.

Reset
REQ-024 SHALL on rst=1 clear valid1, valid2, S1/S2 data, perf_ops, perf_illegal to 0; rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, req_ready=0 during reset.
REQ-025 SHALL give rst priority over flush and any handshake; reset mid-operation drops all in-flight ops without a response.
REQ-026 SHALL assert req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile counters per REQ-023 only when macro ALU_ISSUE_PERF_EN is defined.
REQ-028 SHALL, without ALU_ISSUE_PERF_EN, keep perf_ops and perf_illegal ports, tied to constant 0, with no counter flops.

Verification
REQ-029 SHALL cover: class 10, funct 101010, a=0xFFFFFFFE, b=0x00000001 -> alu_op=1010 in cycle n+1, rsp_result=0x00000001, rsp_zero=0 in cycle n+2.
REQ-030 SHALL cover: class 01, a=b=0x12345678 -> rsp_result=0, rsp_zero=1; class 10 funct 111111 -> alu_op=0000, rsp_illegal=1, perf_illegal=1 after handshake.
REQ-031 SHALL cover: 8 back-to-back ADDs (a=i, b=1), rsp_ready=1 -> 8 consecutive rsp_valid cycles, results 1..8 in order, perf_ops=8.
REQ-032 SHALL cover: rsp_ready=0 for 5 cycles with 3 requests offered -> exactly 2 accepted, req_ready=0 thereafter, rsp_* stable; release -> both delivered in order, third then accepted.
REQ-033 SHALL cover: flush with valid1=valid2=1 and rsp_ready=1 -> no response delivered, perf_ops unchanged, req_ready=0 that cycle, 1 next cycle.
REQ-034 SHALL cover: rst asserted with both stages full -> rsp_valid=0 next cycle, counters 0; build without ALU_ISSUE_PERF_EN -> perf_* always 0.
